// File: rtl/bb_mac_pkg.sv
// Shared definitions for the Bitblade MAC controller: opcodes, FSM encoding,
// mode constants, the activation offset mask and the Bitblade result width.
package bb_mac_pkg;

  localparam logic [2:0] OP_MAC      = 3'd0;
  localparam logic [2:0] OP_CLEAR    = 3'd1;
  localparam logic [2:0] OP_SET_MODE = 3'd2;
  localparam logic [2:0] OP_READ     = 3'd3;

  localparam logic MODE_SIGNED   = 1'b0;
  localparam logic MODE_UNSIGNED = 1'b1;

  localparam logic [31:0] OFFSET_MASK = 32'h8080_8080;
  localparam int          BB_RES_W    = 18;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PASS_HI = 2'd1,
    ST_PASS_LO = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Replicates each byte's sign bit across that byte.
  function automatic logic [31:0] sign_bytes(input logic [31:0] b);
    return {{8{b[31]}}, {8{b[23]}}, {8{b[15]}}, {8{b[7]}}};
  endfunction

endpackage

// File: rtl/bb_mac_accum.sv
// Accumulator with clear and add; the add saturates on signed overflow when
// BB_MAC_SATURATE_EN is defined and wraps otherwise.
module bb_mac_accum
  import bb_mac_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             add_i,
  input  logic [ACC_W-1:0] addend_i,
  output logic [ACC_W-1:0] acc_o,
  output logic [ACC_W-1:0] acc_next_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_raw, sum_fin;

  assign sum_raw = acc_q + addend_i;

`ifdef BB_MAC_SATURATE_EN
  logic ovf;
  // Overflow only when both operands share a sign the result does not.
  assign ovf = (acc_q[ACC_W-1] == addend_i[ACC_W-1]) &&
               (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
  assign sum_fin = !ovf ? sum_raw :
                   acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                    {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign sum_fin = sum_raw;
`endif

  always_comb begin
    acc_d = acc_q;
    if (clear_i)    acc_d = '0;
    else if (add_i) acc_d = sum_fin;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o      = acc_q;
  assign acc_next_o = sum_fin;

endmodule

// File: rtl/bitblade_mac_ctrl.sv
// CPU custom-instruction front end driving a shared external Bitblade for
// int8 dot products. Optional saturation: BB_MAC_SATURATE_EN.
//
// state   | meaning
// IDLE    | ready for a command
// PASS_HI | Bitblade fed sign-replicated filter bytes; result kept as hi
// PASS_LO | Bitblade fed raw filter bytes; accumulate
// RESP    | response held until rsp_ready
module bitblade_mac_ctrl
  import bb_mac_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [9:0]       cmd_payload_function_id,
  input  logic [31:0]      cmd_payload_inputs_0,
  input  logic [31:0]      cmd_payload_inputs_1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ACC_W-1:0] rsp_payload_outputs_0,
  output logic [31:0]      bb_in_a,
  output logic [31:0]      bb_in_b,
  input  logic [BB_RES_W-1:0] bb_out_c
);

  state_t              state_q;
  logic [31:0]         a_q, b_q;
  logic                mode_q, mac_mode_q;
  logic [BB_RES_W-1:0] hi_q;
  logic                rsp_valid_q;
  logic [ACC_W-1:0]    rsp_data_q;

  logic [2:0]       funct3;
  logic             accept;
  logic [15:0]      sum16;
  logic [ACC_W-1:0] mac_sum, acc, acc_next;
  logic             unused_bits;

  assign funct3 = cmd_payload_function_id[2:0];
  assign accept = (state_q == ST_IDLE) && cmd_valid;

  // Only the low 16 bits of (hi<<8)+lo survive, so hi[7:0] is all that matters.
  assign sum16   = {hi_q[7:0], 8'h00} + bb_out_c[15:0];
  assign mac_sum = (mac_mode_q == MODE_SIGNED) ? {{(ACC_W-16){sum16[15]}}, sum16}
                                               : {{(ACC_W-BB_RES_W){1'b0}}, bb_out_c};

  bb_mac_accum #(.ACC_W(ACC_W)) u_accum (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (accept && (funct3 == OP_CLEAR)),
    .add_i      (state_q == ST_PASS_LO),
    .addend_i   (mac_sum),
    .acc_o      (acc),
    .acc_next_o (acc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= MODE_SIGNED;
      mac_mode_q  <= MODE_SIGNED;
      hi_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            a_q        <= cmd_payload_inputs_0 ^ OFFSET_MASK;
            b_q        <= cmd_payload_inputs_1;
            mac_mode_q <= mode_q;
            case (funct3)
              OP_MAC: begin
                state_q <= (mode_q == MODE_SIGNED) ? ST_PASS_HI : ST_PASS_LO;
              end
              OP_SET_MODE: begin
                mode_q      <= cmd_payload_inputs_0[0];
                rsp_data_q  <= {{(ACC_W-1){1'b0}}, mode_q};
                rsp_valid_q <= 1'b1;
                state_q     <= ST_RESP;
              end
              OP_READ: begin
                rsp_data_q  <= acc;
                rsp_valid_q <= 1'b1;
                state_q     <= ST_RESP;
              end
              default: begin
                rsp_data_q  <= '0;
                rsp_valid_q <= 1'b1;
                state_q     <= ST_RESP;
              end
            endcase
          end
        end
        ST_PASS_HI: begin
          hi_q    <= bb_out_c;
          state_q <= ST_PASS_LO;
        end
        ST_PASS_LO: begin
          rsp_data_q  <= acc_next;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready             = (state_q == ST_IDLE);
  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;

  assign bb_in_a = ((state_q == ST_PASS_HI) || (state_q == ST_PASS_LO)) ? a_q : '0;
  assign bb_in_b = (state_q == ST_PASS_HI) ? sign_bytes(b_q) :
                   (state_q == ST_PASS_LO) ? b_q : '0;

  assign unused_bits = ^{cmd_payload_function_id[9:3], hi_q[BB_RES_W-1:8]};

endmodule

// File: tb/tb_bitblade_mac_ctrl.sv
// Self-checking bench for bitblade_mac_ctrl with a behavioural Bitblade and a
// reference model of the accumulator, mode and response latency.
module tb_bitblade_mac_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id = '0;
  logic [31:0] cmd_payload_inputs_0 = '0;
  logic [31:0] cmd_payload_inputs_1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_payload_outputs_0;
  logic [31:0] bb_in_a, bb_in_b;
  logic [17:0] bb_out_c;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_acc = '0;
  bit          model_mode = 1'b0;
  logic [31:0] last_rsp;

  always #5 clk = ~clk;

  bitblade_mac_ctrl #(.ACC_W(32)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .bb_in_a                 (bb_in_a),
    .bb_in_b                 (bb_in_b),
    .bb_out_c                (bb_out_c)
  );

  // Behavioural Bitblade: unsigned sum of four byte products.
  always_comb begin
    int s;
    s = 0;
    for (int l = 0; l < 4; l++) s += int'(bb_in_a[8*l +: 8]) * int'(bb_in_b[8*l +: 8]);
    bb_out_c = 18'(s);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Dot product with activations offset by +128, filter bytes per mode.
  function automatic logic [31:0] model_sum(input bit m, input logic [31:0] in0, input logic [31:0] in1);
    int          hi, lo, a;
    logic [7:0]  ab, fb;
    logic [31:0] t;
    logic [15:0] s16;
    hi = 0;
    lo = 0;
    for (int l = 0; l < 4; l++) begin
      ab = in0[8*l +: 8];
      fb = in1[8*l +: 8];
      a  = int'($signed(ab)) + 128;
      lo += a * int'(fb);
      if (fb[7]) hi += a * 255;
    end
    if (m) return 32'(lo);
    t   = 32'(hi * 256 + lo);
    s16 = t[15:0];
    return {{16{s16[15]}}, s16};
  endfunction

  function automatic logic [31:0] acc_add(input logic [31:0] acc, input logic [31:0] s);
    longint t;
    t = longint'($signed(acc)) + longint'($signed(s));
`ifdef BB_MAC_SATURATE_EN
    if (t > 64'sd2147483647) t = 64'sd2147483647;
    else if (t < -64'sd2147483648) t = -64'sd2147483648;
`endif
    return t[31:0];
  endfunction

  function automatic logic [31:0] sign_mask(input logic [31:0] b);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = b[8*l+7] ? 8'hFF : 8'h00;
    return r;
  endfunction

  // Entered and left just after a falling edge.
  task automatic do_cmd(input logic [2:0] f3, input logic [31:0] in0, input logic [31:0] in1,
                        input int hold);
    logic [31:0] exp;
    int          lat, n;
    bit          is_mac, mm;
    is_mac = (f3 == 3'd0);
    mm     = model_mode;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_payload_function_id = {7'($urandom), f3};
    cmd_payload_inputs_0 = in0;
    cmd_payload_inputs_1 = in1;
    case (f3)
      3'd0: begin
        model_acc = acc_add(model_acc, model_sum(mm, in0, in1));
        exp = model_acc;
        lat = mm ? 2 : 3;
      end
      3'd1: begin model_acc = '0; exp = '0; lat = 1; end
      3'd2: begin exp = 32'(mm); model_mode = in0[0]; lat = 1; end
      3'd3: begin exp = model_acc; lat = 1; end
      default: begin exp = '0; lat = 1; end
    endcase
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_payload_inputs_0 = $urandom;
    cmd_payload_inputs_1 = $urandom;
    n = 1;
    if (is_mac) begin
      check("bb_in_a_pass", bb_in_a, in0 ^ 32'h8080_8080);
      check("bb_in_b_first", bb_in_b, mm ? in1 : sign_mask(in1));
    end
    while (!rsp_valid && n < 8) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (is_mac && !mm && n == 2) check("bb_in_b_lo", bb_in_b, in1);
    end
    check("latency", 32'(n), 32'(lat));
    check("rsp_data", rsp_payload_outputs_0, exp);
    check("bb_in_a_resp", bb_in_a, 32'd0);
    check("bb_in_b_resp", bb_in_b, 32'd0);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_payload_function_id = {7'd0, 3'd1};
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", rsp_payload_outputs_0, exp);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    last_rsp  = rsp_payload_outputs_0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs_valid", 32'(rsp_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_acc  = '0;
    model_mode = 1'b0;
  endtask

  initial begin
    logic [31:0] r, in0, in1;
    logic [2:0]  f3;
    int          n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_payload_outputs_0, 32'd0);
    check("rst_bb_in_a", bb_in_a, 32'd0);
    check("rst_bb_in_b", bb_in_b, 32'd0);
    do_cmd(3'd3, $urandom, $urandom, 0);
    check("rst_acc_zero", last_rsp, 32'd0);

    // Zero activations against unit filters.
    do_cmd(3'd1, 0, 0, 0);
    do_cmd(3'd0, 32'h0000_0000, 32'h0101_0101, 0);
    check("dir_mac_0x200", last_rsp, 32'h0000_0200);

    // Signed filter -1.
    do_cmd(3'd1, 0, 0, 0);
    do_cmd(3'd0, 32'h0000_007F, 32'h0000_00FF, 0);
    check("dir_mac_neg255", last_rsp, 32'hFFFF_FF01);

    // Same operands with unsigned filter.
    do_cmd(3'd1, 0, 0, 0);
    do_cmd(3'd2, 32'h1, 0, 0);
    check("dir_setmode_prev", last_rsp, 32'd0);
    do_cmd(3'd0, 32'h0000_007F, 32'h0000_00FF, 0);
    check("dir_mac_unsigned", last_rsp, 32'h0000_FE01);

    // Back-pressure with a competing command.
    do_cmd(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5);
    do_cmd(3'd3, 0, 0, 0);
    check("dir_read_after_hold", last_rsp, 32'h0000_FE01 + model_sum(1'b1, 32'h1234_5678, 32'h9ABC_DEF0));

    for (int i = 0; i < 200; i++) begin
      f3 = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(0, 7));
      do_cmd(f3, $urandom, $urandom, $urandom_range(0, 3));
    end

    // Reset while the response is waiting.
    do_cmd(3'd2, 32'h1, 0, 0);
    cmd_valid = 1'b1;
    cmd_payload_function_id = 10'd0;
    cmd_payload_inputs_0 = $urandom;
    cmd_payload_inputs_1 = $urandom;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("rst_resp_reached", 32'(rsp_valid), 32'd1);
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      check("rst_resp_no_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    do_cmd(3'd3, 0, 0, 0);
    check("rst_resp_acc", last_rsp, 32'd0);
    do_cmd(3'd2, 32'h0, 0, 0);
    check("rst_resp_mode", last_rsp, 32'd0);

    // Reset during PASS_HI.
    do_cmd(3'd0, 32'h7F7F_7F7F, 32'h0101_0101, 0);
    cmd_valid = 1'b1;
    cmd_payload_function_id = 10'd0;
    cmd_payload_inputs_0 = 32'h7F7F_7F7F;
    cmd_payload_inputs_1 = 32'h8181_8181;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_hi_state", bb_in_b, 32'hFFFF_FFFF);
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      check("rst_hi_no_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    do_cmd(3'd3, 0, 0, 0);
    check("rst_hi_acc", last_rsp, 32'd0);
    do_cmd(3'd2, 32'h1, 0, 0);
    check("rst_hi_mode", last_rsp, 32'd0);

    // Climb to 0x7FFFFF00 with unsigned MACs, then add +512.
    do_cmd(3'd1, 0, 0, 0);
    while (model_acc != 32'h7FFF_FF00) begin
      r = 32'h7FFF_FF00 - model_acc;
      if (r >= 32'd260100) begin in0 = 32'h7F7F_7F7F; in1 = 32'hFFFF_FFFF; end
      else if (r >= 32'd65025) begin in0 = 32'h0000_007F; in1 = 32'h0000_00FF; end
      else if (r >= 32'd255) begin in0 = 32'h0000_007F; in1 = r / 255; end
      else begin in0 = r ^ 32'h80; in1 = 32'h1; end
      do_cmd(3'd0, in0, in1, 0);
    end
    do_cmd(3'd3, 0, 0, 0);
    check("ovf_start", last_rsp, 32'h7FFF_FF00);
    do_cmd(3'd2, 32'h0, 0, 0);
    do_cmd(3'd0, 32'h0000_0000, 32'h0101_0101, 0);
`ifdef BB_MAC_SATURATE_EN
    check("ovf_result", last_rsp, 32'h7FFF_FFFF);
`else
    check("ovf_result", last_rsp, 32'h8000_0100);
`endif
    do_cmd(3'd3, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitblade_mac_ctrl.md
BITBLADE_MAC_CTRL -- requirements
Module: bitblade_mac_ctrl

Interface
REQ-001 Parameter ACC_W, default 32, accumulator and response width; only value 32 is supported.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request from the CPU.
REQ-005 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-006 cmd_payload_function_id  input  10  [2:0] = funct3 opcode; [9:3] = funct7, ignored.
REQ-007 cmd_payload_inputs_0  input  32  four signed int8 activations, lane 0 in [7:0].
REQ-008 cmd_payload_inputs_1  input  32  four int8 filter bytes, lane 0 in [7:0].
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  CPU consumes the response.
REQ-011 rsp_payload_outputs_0  output  32  response data.
REQ-012 bb_in_a  output  32  operand A to the shared external Bitblade: four unsigned 8b lanes.
REQ-013 bb_in_b  output  32  operand B to the shared Bitblade: four unsigned 8b lanes.
REQ-014 bb_out_c  input  18  Bitblade result: combinational, unsigned sum over the four lanes of a_i*b_i.

Function
REQ-015 Opcodes (funct3):
- 0 = MAC
- 1 = CLEAR (acc<=0, response 0)
- 2 = SET_MODE (mode<=inputs_0[0], response = previous mode zero-extended)
- 3 = READ (response = acc)
- 4..7 = response 0, no state change.
REQ-016 FSM states IDLE, PASS_HI, PASS_LO, RESP; cmd_ready is high only in IDLE.
REQ-017 On accept, both operands are latched; later input changes have no effect.
REQ-018 Operand A is formed by inverting bit 7 of every activation byte (XOR 0x80808080), i.e. activation+128.
REQ-019 Mode 0 (signed filter) MAC sequence: IDLE->PASS_HI->PASS_LO->RESP.
- PASS_HI: bb_in_b = each filter byte's sign bit replicated to 8 bits; bb_out_c is registered as hi.
- PASS_LO: bb_in_b = raw filter bytes.
- Sum = ((hi<<8)+lo) mod 2^16, sign-extended to 32 bits.
REQ-020 Mode 1 (unsigned filter) MAC sequence: IDLE->PASS_LO->RESP; sum = lo zero-extended to 32 bits.
REQ-021 In PASS_LO: acc <= acc + sum (wrapping, 32-bit); the response equals the new acc.
REQ-022 Latency from the accept cycle to rsp_valid high:
- MAC mode 0: 3 cycles.
- MAC mode 1: 2 cycles.
- All other opcodes: 1 cycle, via IDLE->RESP.
REQ-023 In RESP, rsp_valid and rsp_payload_outputs_0 are held stable until rsp_ready; on the handshake cycle the FSM goes to IDLE, so a new command is accepted at the earliest one cycle later.
REQ-024 bb_in_a and bb_in_b are 0 whenever the FSM is not in PASS_HI or PASS_LO.
REQ-025 SET_MODE and CLEAR take effect at accept; a mode change never alters a MAC already in flight.

Reset
REQ-026 Reset values: FSM=IDLE, acc=0, mode=0, hi=0, rsp_valid=0, rsp_payload_outputs_0=0, cmd_ready=1 on the cycle after reset.
REQ-027 Reset asserted mid-MAC or mid-RESP aborts the operation; no response is issued and the accumulator update is discarded.

Configuration
REQ-028 With macro BB_MAC_SATURATE_EN defined, the MAC accumulate clamps to 0x7FFFFFFF / 0x80000000 on signed overflow; without it, the accumulate wraps modulo 2^32.

Structure
REQ-029 Shared package bb_mac_pkg holds: opcode constants, FSM state encoding, mode constants, the 0x80808080 offset mask, and the 18-bit Bitblade result width.
REQ-030 One sub-module, bb_mac_accum: 32-bit accumulator with clear, add and optional saturation; the Bitblade itself stays external.

Verification
REQ-031 Mode 0, CLEAR, then MAC inputs_0=0x00000000, inputs_1=0x01010101 -> response 0x00000200 on cycle 3, bb_in_b=0x00000000 in PASS_HI.
REQ-032 Mode 0, acc=0, MAC inputs_0=0x0000007F, inputs_1=0x000000FF -> hi=65025, response 0xFFFFFF01 (-255).
REQ-033 SET_MODE 1, then the same MAC as REQ-032 from acc=0 -> response 0x0000FE01 after 2 cycles; SET_MODE returned 0.
REQ-034 Hold rsp_ready low for 5 cycles -> response stable, cmd_ready low, a concurrent cmd_valid is ignored; READ afterwards returns the unchanged acc.
REQ-035 acc=0x7FFFFF00, then MAC with sum +512 -> 0x7FFFFFFF with BB_MAC_SATURATE_EN, 0x80000100 without it.
REQ-036 Reset asserted in PASS_HI -> no rsp_valid; READ afterwards returns 0 and mode is 0.
